hamming_dec: RTL and testbench

- Receive-side counterpart of the team's Hamming(21,16) encoder.
- Accepts 21-bit even-parity SEC codewords, computes the 5-bit syndrome, corrects any single-bit error and extracts the 16 data bits.
- Two-stage pipeline with valid/ready handshakes on both sides, plus saturating corrected/uncorrectable event counters for link-health monitoring.

---
 rtl/hamming_dec.sv | 116 +++++++++++
 tb/tb_hamming_dec.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_dec.sv
// hamming_dec -- Hamming(21,16) SEC decoder, receive side of hamming_enc.
//
// Takes 21-bit even-parity codewords (bit i = Hamming position i+1), computes
// the 5-bit syndrome, flips the addressed bit for syndromes 1..21, flags
// syndromes 22..31 as uncorrectable, and extracts the 16 data bits.
// Two-stage pipeline with valid/ready on both sides; saturating event counters.
//
// Ports:
//   clk        system clock (rising edge)
//   rst        synchronous, active-low reset
//   iData      received codeword          iValid  codeword valid
//   oReady     decoder accepts iData this cycle (combinational)
//   oData      decoded/corrected data     oValid  oData and flags valid
//   iReady     downstream accepts oData this cycle
//   oCorr      single-bit error corrected in current output word
//   oErr       uncorrectable syndrome (22..31) in current output word
//   oSyndrome  raw syndrome of current output word
//   iClrCnt    synchronous clear of both counters
//   oCorrCnt   saturating count of transferred words with oCorr=1
//   oErrCnt    saturating count of transferred words with oErr=1
module hamming_dec #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [20:0]      iData,
  input  logic             iValid,
  output logic             oReady,
  output logic [15:0]      oData,
  output logic             oValid,
  input  logic             iReady,
  output logic             oCorr,
  output logic             oErr,
  output logic [4:0]       oSyndrome,
  input  logic             iClrCnt,
  output logic [CNT_W-1:0] oCorrCnt,
  output logic [CNT_W-1:0] oErrCnt
);

  logic        advance;
  logic        xfer;
  logic        s1Valid;
  logic [20:0] s1Code;
  logic [4:0]  s1Syn;
  logic [4:0]  syn;
  logic [20:0] fixed;
  logic [15:0] dataNext;
  logic        corrNext;
  logic        errNext;

  // Both stages move together; the output register frees up when empty or
  // when its word is being taken downstream.
  assign advance = !oValid || iReady;
  assign oReady  = advance && rst;
  assign xfer    = oValid && iReady;

  // XOR of the positions of all set bits gives the syndrome directly.
  always_comb begin
    syn = '0;
    for (int unsigned i = 0; i < 21; i++) begin
      if (iData[i]) syn = syn ^ 5'(i + 1);
    end
  end

  always_comb begin
    fixed    = s1Code;
    corrNext = 1'b0;
    errNext  = 1'b0;
    if (s1Syn >= 5'd22) begin
      errNext = 1'b1;
    end else if (s1Syn != 5'd0) begin
      corrNext               = 1'b1;
      fixed[s1Syn - 5'd1]    = ~s1Code[s1Syn - 5'd1];
    end
    // Data sits at the non-power-of-two positions, ascending.
    dataNext = {fixed[20:16], fixed[14:8], fixed[6:4], fixed[2]};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1Valid   <= 1'b0;
      s1Code    <= '0;
      s1Syn     <= '0;
      oValid    <= 1'b0;
      oData     <= '0;
      oCorr     <= 1'b0;
      oErr      <= 1'b0;
      oSyndrome <= '0;
    end else if (advance) begin
      s1Valid <= iValid;
      s1Code  <= iData;
      s1Syn   <= syn;
      oValid  <= s1Valid;
      if (s1Valid) begin
        oData     <= dataNext;
        oCorr     <= corrNext;
        oErr      <= errNext;
        oSyndrome <= s1Syn;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      oCorrCnt <= '0;
      oErrCnt  <= '0;
    end else if (iClrCnt) begin
      oCorrCnt <= '0;
      oErrCnt  <= '0;
    end else if (xfer) begin
      if (oCorr && (oCorrCnt != '1)) oCorrCnt <= oCorrCnt + 1'b1;
      if (oErr && (oErrCnt != '1))   oErrCnt  <= oErrCnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hamming_dec.sv
// tb_hamming_dec -- self-checking bench for hamming_dec.
// A queue of accepted codewords is decoded by a position-arithmetic model;
// one negedge process compares outputs, latency and counters every cycle.
// A second instance with CNT_W=2 exercises counter saturation.
module tb_hamming_dec;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [20:0] iData = '0;
  logic        iValid = 1'b0;
  logic        oReady;
  logic [15:0] oData;
  logic        oValid;
  logic        iReady = 1'b1;
  logic        oCorr;
  logic        oErr;
  logic [4:0]  oSyndrome;
  logic        iClrCnt = 1'b0;
  logic [15:0] oCorrCnt;
  logic [15:0] oErrCnt;

  logic        sReady;
  logic [15:0] sData;
  logic        sValid;
  logic        sCorr;
  logic        sErr;
  logic [4:0]  sSyndrome;
  logic [1:0]  sCorrCnt;
  logic [1:0]  sErrCnt;

  hamming_dec #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .iData(iData), .iValid(iValid), .oReady(oReady),
    .oData(oData), .oValid(oValid), .iReady(iReady), .oCorr(oCorr), .oErr(oErr),
    .oSyndrome(oSyndrome), .iClrCnt(iClrCnt), .oCorrCnt(oCorrCnt), .oErrCnt(oErrCnt)
  );

  hamming_dec #(.CNT_W(2)) dutSat (
    .clk(clk), .rst(rst), .iData(iData), .iValid(iValid), .oReady(sReady),
    .oData(sData), .oValid(sValid), .iReady(iReady), .oCorr(sCorr), .oErr(sErr),
    .oSyndrome(sSyndrome), .iClrCnt(iClrCnt), .oCorrCnt(sCorrCnt), .oErrCnt(sErrCnt)
  );

  always #5 clk = ~clk;

  int nTests = 0;
  int nFail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int synOf(input logic [20:0] c);
    int s = 0;
    for (int p = 1; p <= 21; p++) if (c[p-1]) s = s ^ p;
    return s;
  endfunction

  function automatic bit isPow2(input int p);
    return (p & (p - 1)) == 0;
  endfunction

  function automatic void decode(input logic [20:0] cIn, output logic [15:0] d,
                                 output logic [4:0] s, output logic corr, output logic err);
    logic [20:0] c = cIn;
    int sy = synOf(cIn);
    int j = 0;
    s    = 5'(sy);
    corr = (sy >= 1) && (sy <= 21);
    err  = (sy >= 22);
    if (corr) c[sy-1] = ~c[sy-1];
    d = '0;
    for (int p = 1; p <= 21; p++) begin
      if (!isPow2(p)) begin
        d[j] = c[p-1];
        j++;
      end
    end
  endfunction

  function automatic logic [20:0] encode(input logic [15:0] d);
    logic [20:0] c = '0;
    int j = 0;
    int s;
    for (int p = 1; p <= 21; p++) begin
      if (!isPow2(p)) begin
        c[p-1] = d[j];
        j++;
      end
    end
    s = synOf(c);
    for (int k = 0; k < 5; k++) if (s[k]) c[(1 << k) - 1] = 1'b1;
    return c;
  endfunction

  typedef struct {
    logic [20:0] code;
    int          acc;
    int          stalls;
    bit          shown;
  } ent_t;

  ent_t q[$];
  int   cyc = 0;
  bit   resetEdge = 1'b1;
  int   mCorr16 = 0, mErr16 = 0, mCorr2 = 0, mErr2 = 0;

  always @(negedge clk) begin
    logic [15:0] d;
    logic [4:0]  s;
    logic        cr, er;
    cyc++;
    chk("oReady", oReady, rst && (!oValid || iReady));
    if (resetEdge) begin
      chk("rst_oValid", oValid, 1'b0);
      chk("rst_oData", oData, 16'h0);
      chk("rst_flags", {oCorr, oErr}, 2'b00);
      chk("rst_syn", oSyndrome, 5'd0);
    end else if (oValid) begin
      if (q.size() == 0) begin
        chk("spurious_oValid", oValid, 1'b0);
      end else begin
        decode(q[0].code, d, s, cr, er);
        chk("oData", oData, d);
        chk("oSyndrome", oSyndrome, s);
        chk("oCorr", oCorr, cr);
        chk("oErr", oErr, er);
        if (!q[0].shown) begin
          chk("latency", cyc, q[0].acc + 2 + q[0].stalls);
          q[0].shown = 1'b1;
        end
      end
    end else if (q.size() != 0 && cyc >= q[0].acc + 2 + q[0].stalls) begin
      chk("late_oValid", oValid, 1'b1);
    end
    chk("corrCnt", oCorrCnt, mCorr16);
    chk("errCnt", oErrCnt, mErr16);
    chk("corrCnt2", sCorrCnt, mCorr2);
    chk("errCnt2", sErrCnt, mErr2);

    // Advance the model to the coming clock edge.
    if (!rst) begin
      q.delete();
      mCorr16 = 0; mErr16 = 0; mCorr2 = 0; mErr2 = 0;
      resetEdge = 1'b1;
    end else begin
      resetEdge = 1'b0;
      if (oValid && !iReady) begin
        for (int i = 0; i < q.size(); i++)
          if (!q[i].shown) q[i].stalls = q[i].stalls + 1;
      end
      if (oValid && iReady && q.size() != 0) begin
        decode(q[0].code, d, s, cr, er);
        void'(q.pop_front());
        if (cr) begin
          if (mCorr16 < 65535) mCorr16++;
          if (mCorr2 < 3) mCorr2++;
        end
        if (er) begin
          if (mErr16 < 65535) mErr16++;
          if (mErr2 < 3) mErr2++;
        end
      end
      if (iClrCnt) begin
        mCorr16 = 0; mErr16 = 0; mCorr2 = 0; mErr2 = 0;
      end
      if (iValid && oReady) begin
        ent_t e;
        e.code = iData; e.acc = cyc; e.stalls = 0; e.shown = 1'b0;
        q.push_back(e);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [20:0] c);
    bit acc;
    int n = 0;
    iData  = c;
    iValid = 1'b1;
    do begin
      @(negedge clk);
      acc = oReady;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) chk("accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic idle(input int n);
    iValid = 1'b0;
    iData  = 21'($urandom);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  bit randOn = 1'b0;

  initial begin
    logic [15:0] d;
    logic [4:0]  s;
    logic        cr, er;
    logic [20:0] w;

    // Pin the model against hand-computed values.
    decode(21'h000017, d, s, cr, er);
    chk("pin_17", {d, 3'b0, s, 6'b0, cr, er}, {16'h0001, 3'b0, 5'd5, 6'b0, 1'b1, 1'b0});
    decode(21'h080002, d, s, cr, er);
    chk("pin_80002", {d, 3'b0, s, 6'b0, cr, er}, {16'h4000, 3'b0, 5'd22, 6'b0, 1'b0, 1'b1});
    decode(21'h000003, d, s, cr, er);
    chk("pin_3", {d, 3'b0, s, 6'b0, cr, er}, {16'h0001, 3'b0, 5'd3, 6'b0, 1'b1, 1'b0});
    decode(21'h1FFFFE, d, s, cr, er);
    chk("pin_1FFFFE", {d, 3'b0, s, 6'b0, cr, er}, {16'hFFFF, 3'b0, 5'd0, 6'b0, 1'b0, 1'b0});
    chk("pin_enc1", encode(16'h0001), 21'h000007);
    chk("pin_encF", encode(16'hFFFF), 21'h1FFFFE);

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;

    // Clean words back-to-back.
    send(21'h000000);
    send(21'h000007);
    send(21'h1FFFFE);
    idle(4);

    // Single errors, then uncorrectable / miscorrection.
    send(21'h000017);
    for (int i = 0; i < 21; i++) begin
      w = 21'h1FFFFE;
      w[i] = ~w[i];
      send(w);
    end
    send(21'h080002);
    send(21'h000003);
    idle(4);
    chk("corrCnt_dir", oCorrCnt, 16'd23);
    chk("errCnt_dir", oErrCnt, 16'd1);

    // Backpressure mid-stream.
    fork
      begin
        send(21'h000017);
        send(21'h080002);
        send(21'h000007);
        send(21'h000003);
        iValid = 1'b0;
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        iReady = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        iReady = 1'b1;
      end
    join
    idle(6);

    // Clear on the same cycle as a corrected transfer.
    send(21'h000017);
    iValid = 1'b0;
    @(posedge clk);
    #1;
    iClrCnt = 1'b1;
    @(posedge clk);
    #1;
    iClrCnt = 1'b0;
    chk("clr_wins", oCorrCnt, 16'd0);
    chk("clr_wins2", sCorrCnt, 2'd0);
    idle(3);

    // Randomized traffic.
    randOn = 1'b1;
    fork
      begin
        for (int n = 0; n < 400; n++) begin
          int r = $urandom_range(0, 9);
          w = encode(16'($urandom));
          if (r < 4) w[$urandom_range(0, 20)] ^= 1'b1;
          else if (r < 6) w = 21'($urandom);
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
          send(w);
        end
        iValid = 1'b0;
        randOn = 1'b0;
      end
      begin
        while (randOn) begin
          @(posedge clk);
          #1;
          iReady  = ($urandom_range(0, 3) != 0);
          iClrCnt = ($urandom_range(0, 49) == 0);
        end
        iReady  = 1'b1;
        iClrCnt = 1'b0;
      end
    join
    iReady  = 1'b1;
    iClrCnt = 1'b0;
    idle(6);

    // Reset with two words in flight.
    send(21'h000017);
    send(21'h000003);
    iValid = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    send(21'h1FFFFE);
    idle(1);

    begin
      int n = 0;
      while (q.size() != 0 && n < 100) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk("drain", q.size(), 0);
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
